// File: rtl/button_conditioner.sv
// Debounced pushbutton front end: synchronizer, debounce FSM and press strobe.
// Define BUTTON_NEGEDGE_EN to add the one-cycle release strobe button_negedge.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button_state,
    output logic button_posedge
`ifdef BUTTON_NEGEDGE_EN
    ,
    output logic button_negedge
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_in;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   pos_q;
    logic                   pos_d;
`ifdef BUTTON_NEGEDGE_EN
    logic                   neg_q;
    logic                   neg_d;
`endif

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], button_raw};
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pos_d   = 1'b0;
`ifdef BUTTON_NEGEDGE_EN
        neg_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sync_in) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pos_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (!sync_in) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A high sample here is a release bounce: stay pressed, no strobe.
                if (sync_in) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef BUTTON_NEGEDGE_EN
                    neg_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pos_q   <= 1'b0;
`ifdef BUTTON_NEGEDGE_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pos_q   <= pos_d;
`ifdef BUTTON_NEGEDGE_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign button_state   = level_q;
    assign button_posedge = pos_q;
`ifdef BUTTON_NEGEDGE_EN
    assign button_negedge = neg_q;
`endif

endmodule
